pingpong_filler: RTL and testbench

Upstream write controller for the 2×256-word ping-pong buffer. Accepts a 32-bit word stream with valid/ready handshake and writes it into the half currently owned by the write side (port A). It closes a block when the block is full or the producer marks the last word. It pulses the buffer's `switch` to hand the block to the consumer, and blocks further input until the consumer reports the other half drained.

---
 rtl/pingpong_pkg.sv | 16 +
 rtl/pingpong_idle_timer.sv | 33 +++
 rtl/pingpong_filler.sv | 134 +++++++++++++
 tb/tb_pingpong_filler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared types and sizes for the ping-pong buffer write side.
// Holds the filler state enum and the data/address widths.
package pingpong_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BUF_ADDR_WIDTH = 9;
  localparam int HALF_DEPTH     = 256;
  localparam int IDLE_WIDTH     = 16;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    WAIT_DRAIN = 2'd1,
    SWITCH     = 2'd2
  } state_e;

endpackage

// File: rtl/pingpong_idle_timer.sv
// Idle-cycle counter with clear, enable and terminal-count output.
// Ports: clock, reset (async low), clr, en in; tc out (LIMIT-th enabled cycle).
module pingpong_idle_timer
  import pingpong_pkg::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [IDLE_WIDTH-1:0] TC_VAL = IDLE_WIDTH'(LIMIT - 1);

  logic [IDLE_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // tc fires during the LIMIT-th consecutive enabled cycle
  assign tc = en & ~clr & (cnt_q == TC_VAL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pingpong_filler.sv
// Write-side controller for the 2x256 ping-pong buffer: fills port A,
// closes blocks on full/inLast, pulses bufSwitch and waits for drainDone.
// Ports: clock, reset (async low); inValid/inData/inLast/inReady producer;
// bufAddress/bufWriteEnable/bufDataOut/bufSwitch buffer; drainDone,
// blockValid/blockWords consumer. Option: PINGPONG_FILLER_TIMEOUT_EN.
module pingpong_filler
  import pingpong_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inValid,
  input  logic [DATA_WIDTH-1:0]     inData,
  input  logic                      inLast,
  output logic                      inReady,
  output logic [BUF_ADDR_WIDTH-1:0] bufAddress,
  output logic                      bufWriteEnable,
  output logic [DATA_WIDTH-1:0]     bufDataOut,
  output logic                      bufSwitch,
  input  logic                      drainDone,
  output logic                      blockValid,
  output logic [BUF_ADDR_WIDTH-1:0] blockWords
);

  localparam logic [8:0] LAST_CNT = 9'(BLOCK_WORDS);

  state_e                    state_q, state_d;
  logic [8:0]                count_q, count_d;
  logic                      we_q, we_d;
  logic [BUF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      sw_q, sw_d;
  logic                      bv_q, bv_d;
  logic [8:0]                bw_q, bw_d;

  logic       hs;
  logic       timeout;
  logic [8:0] count_inc;

  assign inReady   = (state_q == FILL);
  assign hs        = inValid & inReady;
  assign count_inc = count_q + 9'd1;

`ifdef PINGPONG_FILLER_TIMEOUT_EN
  logic idle_clr, idle_en;

  assign idle_clr = hs | (state_q != FILL);
  assign idle_en  = (state_q == FILL) & (count_q != 9'd0) & ~hs;

  pingpong_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle (
    .clock (clock),
    .reset (reset),
    .clr   (idle_clr),
    .en    (idle_en),
    .tc    (timeout)
  );
`else
  // never true for a legal TIMEOUT_CYCLES
  assign timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = hs;
    addr_d  = addr_q;
    data_d  = data_q;
    sw_d    = 1'b0;
    bv_d    = bv_q;
    bw_d    = bw_q;

    if (hs) begin
      addr_d  = {1'b0, count_q[7:0]};
      data_d  = inData;
      count_d = count_inc;
    end

    if (drainDone) bv_d = 1'b0;

    unique case (state_q)
      FILL: begin
        if ((hs & (inLast | (count_inc == LAST_CNT))) | timeout)
          state_d = WAIT_DRAIN;
      end
      WAIT_DRAIN: begin
        if (!bv_q) begin
          state_d = SWITCH;
          sw_d    = 1'b1;
        end
      end
      SWITCH: begin
        bv_d    = 1'b1;
        bw_d    = count_q;
        count_d = 9'd0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sw_q    <= 1'b0;
      bv_q    <= 1'b0;
      bw_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sw_q    <= sw_d;
      bv_q    <= bv_d;
      bw_q    <= bw_d;
    end
  end

  assign bufWriteEnable = we_q;
  assign bufAddress     = addr_q;
  assign bufDataOut     = data_q;
  assign bufSwitch      = sw_q;
  assign blockValid     = bv_q;
  assign blockWords     = bw_q;

endmodule

// File: tb/tb_pingpong_filler.sv
// Bench for pingpong_filler: directed scenarios plus random traffic,
// checked every cycle against an event-level model of the block rules.
module tb_pingpong_filler;

  localparam int BW = 256;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] inData = '0;
  logic        inLast = 1'b0;
  logic        drainDone = 1'b0;
  logic        inReady;
  logic [8:0]  bufAddress;
  logic        bufWriteEnable;
  logic [31:0] bufDataOut;
  logic        bufSwitch;
  logic        blockValid;
  logic [8:0]  blockWords;

  pingpong_filler #(
    .BLOCK_WORDS    (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .inValid        (inValid),
    .inData         (inData),
    .inLast         (inLast),
    .inReady        (inReady),
    .bufAddress     (bufAddress),
    .bufWriteEnable (bufWriteEnable),
    .bufDataOut     (bufDataOut),
    .bufSwitch      (bufSwitch),
    .drainDone      (drainDone),
    .blockValid     (blockValid),
    .blockWords     (blockWords)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          t;
    logic [8:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];
  int  m_words, m_pend, m_close_cyc, m_idle, m_bw;
  bit  m_closed, m_bv, m_bv_prev;

  int  sw_cnt = 0, last_sw_cyc = -1, bv_rise_cyc = -1;
  int  we_cnt = 0;
  int  first_addr = -1;
  bit  want_first = 0, prev_bv_obs = 0;

  task automatic m_close(int c);
    m_closed    = 1;
    m_close_cyc = c;
    m_pend      = m_words;
    m_words     = 0;
    m_idle      = 0;
  endtask

  always @(negedge clock) begin
    bit hs, sw_e, we_e;
    if (!reset) begin
      chk("rst_ready", inReady, 1);
      chk("rst_we", bufWriteEnable, 0);
      chk("rst_addr", bufAddress, 0);
      chk("rst_data", bufDataOut, 0);
      chk("rst_switch", bufSwitch, 0);
      chk("rst_bv", blockValid, 0);
      chk("rst_bw", blockWords, 0);
      wq.delete();
      m_words = 0; m_pend = 0; m_idle = 0; m_bw = 0;
      m_closed = 0; m_bv = 0; m_bv_prev = 0;
      prev_bv_obs = 0;
    end else begin
      hs   = inValid && !m_closed;
      // consumer side must have been free during the previous cycle
      sw_e = m_closed && (cyc >= m_close_cyc + 2) && !m_bv_prev;
      we_e = (wq.size() > 0) && (wq[0].t == cyc);

      chk("ready", inReady, !m_closed);
      chk("switch", bufSwitch, sw_e);
      chk("bv", blockValid, m_bv);
      if (m_bv) chk("bw", blockWords, m_bw);
      chk("we", bufWriteEnable, we_e);
      if (we_e) begin
        chk("addr", bufAddress, wq[0].a);
        chk("data", bufDataOut, wq[0].d);
        void'(wq.pop_front());
      end

      if (bufSwitch) begin sw_cnt++; last_sw_cyc = cyc; end
      if (blockValid && !prev_bv_obs) bv_rise_cyc = cyc;
      prev_bv_obs = blockValid;
      if (bufWriteEnable) begin
        we_cnt++;
        if (want_first) begin first_addr = bufAddress; want_first = 0; end
      end

      m_bv_prev = m_bv;
      if (drainDone) m_bv = 0;
      if (sw_e) begin m_bv = 1; m_bw = m_pend; m_closed = 0; end
      if (hs) begin
        wq.push_back('{cyc + 1, 9'(m_words % 256), inData});
        m_words++;
        m_idle = 0;
        if (inLast || m_words == BW) m_close(cyc);
      end
`ifdef PINGPONG_FILLER_TIMEOUT_EN
      else if (!m_closed && m_words > 0) begin
        m_idle++;
        if (m_idle == TO) m_close(cyc);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit last, output int hc);
    int k = 0;
    inValid = 1; inData = d; inLast = last;
    forever begin
      @(negedge clock);
      if (inReady) break;
      k++;
      if (k > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got no inReady want 1");
        break;
      end
    end
    hc = cyc;
    tick();
    inValid = 0; inLast = 0;
  endtask

  task automatic wait_bv();
    int k = 0;
    forever begin
      @(negedge clock);
      if (blockValid) break;
      k++;
      if (k > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_bv: got blockValid 0 want 1");
        break;
      end
    end
    tick();
  endtask

  task automatic pulse_drain(output int dc);
    drainDone = 1;
    dc = cyc;
    tick();
    drainDone = 0;
  endtask

  task automatic do_reset();
    inValid = 0; inLast = 0; drainDone = 0;
    reset = 0;
    repeat (3) tick();
    reset = 1;
    tick();
  endtask

  initial begin
    int h, base, dc, s0;
    repeat (3) tick();
    reset = 1;
    tick();

    // full block, constant valid
    we_cnt = 0;
    for (int i = 0; i < BW; i++) begin
      send(32'(i), 0, h);
      if (i == 0) base = h;
    end
    wait_bv();
    chk("full_sw_cyc", last_sw_cyc - base, 257);
    chk("full_bv_cyc", bv_rise_cyc - base, 258);
    chk("full_bw", blockWords, 256);
    chk("full_writes", we_cnt, 256);

    // short block after draining the full one
    pulse_drain(dc);
    we_cnt = 0; want_first = 1;
    for (int i = 0; i < 5; i++) send(32'hA0 + 32'(i), i == 4, h);
    wait_bv();
    chk("short_bw", blockWords, 5);
    chk("short_writes", we_cnt, 5);
    chk("short_first_addr", first_addr, 0);

    // backpressure: block of 5 still pending
    we_cnt = 0; want_first = 1;
    for (int i = 0; i < BW; i++) send(32'hB000 + 32'(i), 0, h);
    s0 = sw_cnt;
    repeat (20) tick();
    @(negedge clock);
    chk("bp_ready", inReady, 0);
    chk("bp_no_switch", sw_cnt, s0);
    tick();
    pulse_drain(dc);
    repeat (5) tick();
    chk("bp_sw_delay", last_sw_cyc - dc, 2);
    chk("bp_bw", blockWords, 256);
    chk("bp_first_addr", first_addr, 0);
    chk("bp_writes", we_cnt, 256);

    // stray drainDone right after reset
    do_reset();
    pulse_drain(dc);
    repeat (3) tick();
    @(negedge clock);
    chk("stray_bv", blockValid, 0);
    chk("stray_ready", inReady, 1);
    tick();

    // reset in the middle of a block
    s0 = sw_cnt;
    for (int i = 0; i < 100; i++) send(32'hC00 + 32'(i), 0, h);
    reset = 0;
    #1;
    chk("midrst_we", bufWriteEnable, 0);
    chk("midrst_ready", inReady, 1);
    repeat (2) tick();
    reset = 1;
    tick();
    chk("midrst_no_switch", sw_cnt, s0);
    for (int i = 0; i < 3; i++) send(32'hD0 + 32'(i), i == 2, h);
    wait_bv();
    chk("midrst_bw", blockWords, 3);
    chk("midrst_one_switch", sw_cnt, s0 + 1);

`ifdef PINGPONG_FILLER_TIMEOUT_EN
    pulse_drain(dc);
    for (int i = 0; i < 3; i++) send(32'hE0 + 32'(i), 0, h);
    repeat (15) tick();
    chk("to_sw_delay", last_sw_cyc - h, 10);
    chk("to_bw", blockWords, 3);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      inValid   = ($urandom_range(0, 9) < (((i / 200) % 2) ? 7 : 1));
      inData    = $urandom;
      inLast    = ($urandom_range(0, 19) == 0);
      drainDone = ($urandom_range(0, 11) == 0);
      tick();
    end
    inValid = 0; inLast = 0; drainDone = 0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
